// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I-subset controller: FSM states,
// trap causes, opcodes and the datapath control-field codes.
package ctrl_pkg;

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_TRAP = 3'd5
    } state_t;

    localparam logic CAUSE_ILLEGAL = 1'b0;
    localparam logic CAUSE_TIMEOUT = 1'b1;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_S    = 7'b0100011;
    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [2:0] ALU_OP_AND = 3'd0;
    localparam logic [2:0] ALU_OP_OR  = 3'd1;
    localparam logic [2:0] ALU_OP_ADD = 3'd2;
    localparam logic [2:0] ALU_OP_SUB = 3'd3;
    localparam logic [2:0] ALU_OP_XOR = 3'd4;
    localparam logic [2:0] ALU_OP_SLL = 3'd5;
    localparam logic [2:0] ALU_OP_SRL = 3'd6;
    localparam logic [2:0] ALU_OP_SRA = 3'd7;

    localparam logic ALUB_SEL_RS2 = 1'b0;
    localparam logic ALUB_SEL_IMM = 1'b1;

    localparam logic [2:0] SEXT_OP_DEFAULT = 3'd0;
    localparam logic [2:0] SEXT_OP_I       = 3'd1;
    localparam logic [2:0] SEXT_OP_S       = 3'd2;
    localparam logic [2:0] SEXT_OP_B       = 3'd3;
    localparam logic [2:0] SEXT_OP_U       = 3'd4;
    localparam logic [2:0] SEXT_OP_J       = 3'd5;
    localparam logic [2:0] SEXT_OP_SHAMT   = 3'd6;

    localparam logic [1:0] NPC_OP_PC4  = 2'd0;
    localparam logic [1:0] NPC_OP_BR   = 2'd1;
    localparam logic [1:0] NPC_OP_JMP  = 2'd2;
    localparam logic [1:0] NPC_OP_JALR = 2'd3;

    localparam logic [1:0] RF_WSEL_ALU  = 2'd0;
    localparam logic [1:0] RF_WSEL_DRAM = 2'd1;
    localparam logic [1:0] RF_WSEL_PC4  = 2'd2;
    localparam logic [1:0] RF_WSEL_SEXT = 2'd3;

    localparam logic WRITE = 1'b1;
    localparam logic READ  = 1'b0;

    typedef enum logic [3:0] {
        CLS_R, CLS_I, CLS_LOAD, CLS_S, CLS_B, CLS_LUI, CLS_JAL, CLS_JALR, CLS_ILL
    } op_class_t;

    typedef struct packed {
        op_class_t  cls;
        logic [2:0] alu_op;
        logic       alub_sel;
        logic [2:0] sext_op;
        logic [1:0] npc_op;
        logic [1:0] rf_wsel;
    } ctrl_t;

    localparam ctrl_t CTRL_RESET = '{
        cls:      CLS_ILL,
        alu_op:   ALU_OP_AND,
        alub_sel: ALUB_SEL_RS2,
        sext_op:  SEXT_OP_DEFAULT,
        npc_op:   NPC_OP_PC4,
        rf_wsel:  RF_WSEL_ALU
    };

    // Shared by R and I formats; only R-type honours funct7 for SUB.
    function automatic logic [2:0] alu_from_f3(input logic [2:0] f3,
                                               input logic       alt,
                                               input logic       allow_sub);
        case (f3)
            3'b000:  return (alt && allow_sub) ? ALU_OP_SUB : ALU_OP_ADD;
            3'b111:  return ALU_OP_AND;
            3'b110:  return ALU_OP_OR;
            3'b100:  return ALU_OP_XOR;
            3'b001:  return ALU_OP_SLL;
            3'b101:  return alt ? ALU_OP_SRA : ALU_OP_SRL;
            default: return ALU_OP_AND;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode/funct to datapath control-field table; the multi-cycle
// controller samples its result during ID.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output ctrl_t      ctrl
);

    logic alt;
    logic shift_imm;

    assign alt       = (funct7 == F7_ALT);
    assign shift_imm = (funct3 == 3'b001) || (funct3 == 3'b101);

    always_comb begin
        // NOTE: default every output first so no path through the case infers a latch.
        ctrl = CTRL_RESET;
        case (opcode)
            OP_R:    ctrl = '{cls: CLS_R, alu_op: alu_from_f3(funct3, alt, 1'b1),
                              alub_sel: ALUB_SEL_RS2, sext_op: SEXT_OP_DEFAULT,
                              npc_op: NPC_OP_PC4, rf_wsel: RF_WSEL_ALU};
            OP_I:    ctrl = '{cls: CLS_I, alu_op: alu_from_f3(funct3, alt, 1'b0),
                              alub_sel: ALUB_SEL_IMM,
                              sext_op: shift_imm ? SEXT_OP_SHAMT : SEXT_OP_I,
                              npc_op: NPC_OP_PC4, rf_wsel: RF_WSEL_ALU};
            OP_LOAD: ctrl = '{cls: CLS_LOAD, alu_op: ALU_OP_ADD, alub_sel: ALUB_SEL_IMM,
                              sext_op: SEXT_OP_I, npc_op: NPC_OP_PC4,
                              rf_wsel: RF_WSEL_DRAM};
            OP_S:    ctrl = '{cls: CLS_S, alu_op: ALU_OP_ADD, alub_sel: ALUB_SEL_IMM,
                              sext_op: SEXT_OP_S, npc_op: NPC_OP_PC4,
                              rf_wsel: RF_WSEL_ALU};
            OP_B:    ctrl = '{cls: CLS_B, alu_op: ALU_OP_SUB, alub_sel: ALUB_SEL_RS2,
                              sext_op: SEXT_OP_B, npc_op: NPC_OP_BR,
                              rf_wsel: RF_WSEL_ALU};
            OP_LUI:  ctrl = '{cls: CLS_LUI, alu_op: ALU_OP_AND, alub_sel: ALUB_SEL_IMM,
                              sext_op: SEXT_OP_U, npc_op: NPC_OP_PC4,
                              rf_wsel: RF_WSEL_SEXT};
            OP_JAL:  ctrl = '{cls: CLS_JAL, alu_op: ALU_OP_AND, alub_sel: ALUB_SEL_RS2,
                              sext_op: SEXT_OP_J, npc_op: NPC_OP_JMP,
                              rf_wsel: RF_WSEL_PC4};
            OP_JALR: ctrl = '{cls: CLS_JALR, alu_op: ALU_OP_ADD, alub_sel: ALUB_SEL_IMM,
                              sext_op: SEXT_OP_I, npc_op: NPC_OP_JALR,
                              rf_wsel: RF_WSEL_PC4};
            default: ctrl = CTRL_RESET;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM: IF/ID/EX/MEM/WB sequencing with req/ack memory
// handshakes, ack timeout, illegal-opcode trap and a retired-instruction count.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    input  logic             imem_ack,
    input  logic             dmem_ack,
    input  logic             trap_clr,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             ram_we,
    output logic             ir_we,
    output logic             pc_we,
    output logic             rf_we,
    output logic [2:0]       alu_op,
    output logic             alub_sel,
    output logic [2:0]       sext_op,
    output logic [1:0]       npc_op,
    output logic [1:0]       rf_wsel,
    output logic [2:0]       state,
    output logic             trap,
    output logic             trap_cause,
    output logic [CNT_W-1:0] retired
);

    localparam int unsigned          WAIT_W   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0]    WAIT_MAX = WAIT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    state_t            cur_state;
    ctrl_t             dec;
    ctrl_t             ctrl_q;
    logic [WAIT_W-1:0] wait_cnt;
    logic              timeout_hit;

    ctrl_decode u_decode (
        .opcode (opcode),
        .funct3 (funct3),
        .funct7 (funct7),
        .ctrl   (dec)
    );

    assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == WAIT_MAX);

    // Requests and strobes decode straight from the state register so an
    // asynchronous reset drops them in the same cycle.
    assign imem_req = (cur_state == S_IF);
    assign dmem_req = (cur_state == S_MEM);
    assign ram_we   = (cur_state == S_MEM && ctrl_q.cls == CLS_S) ? WRITE : READ;
    assign ir_we    = (cur_state == S_IF) && imem_ack;
    assign rf_we    = (cur_state == S_WB);
    assign pc_we    = ((cur_state == S_EX)  && (ctrl_q.cls == CLS_B))
                    | ((cur_state == S_MEM) && dmem_ack && (ctrl_q.cls == CLS_S))
                    | (cur_state == S_WB);

    assign alu_op   = ctrl_q.alu_op;
    assign alub_sel = ctrl_q.alub_sel;
    assign sext_op  = ctrl_q.sext_op;
    assign npc_op   = ctrl_q.npc_op;
    assign rf_wsel  = ctrl_q.rf_wsel;
    assign state    = cur_state;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_state  <= S_IF;
            ctrl_q     <= CTRL_RESET;
            trap       <= 1'b0;
            trap_cause <= CAUSE_ILLEGAL;
            retired    <= '0;
            wait_cnt   <= '0;
        end else begin
            if (pc_we)
                retired <= retired + 1'b1;

            case (cur_state)
                S_IF: begin
                    if (imem_ack) begin
                        cur_state <= S_ID;
                    end else if (timeout_hit) begin
                        trap       <= 1'b1;
                        trap_cause <= CAUSE_TIMEOUT;
                        cur_state  <= S_TRAP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_ID: begin
                    if (dec.cls == CLS_ILL) begin
                        trap       <= 1'b1;
                        trap_cause <= CAUSE_ILLEGAL;
                        cur_state  <= S_TRAP;
                    end else begin
                        ctrl_q    <= dec;
                        cur_state <= S_EX;
                    end
                end
                S_EX: begin
                    wait_cnt <= '0;
                    case (ctrl_q.cls)
                        CLS_B:           cur_state <= S_IF;
                        CLS_LOAD, CLS_S: cur_state <= S_MEM;
                        default:         cur_state <= S_WB;
                    endcase
                end
                S_MEM: begin
                    if (dmem_ack) begin
                        wait_cnt  <= '0;
                        cur_state <= (ctrl_q.cls == CLS_S) ? S_IF : S_WB;
                    end else if (timeout_hit) begin
                        trap       <= 1'b1;
                        trap_cause <= CAUSE_TIMEOUT;
                        cur_state  <= S_TRAP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_WB: begin
                    wait_cnt  <= '0;
                    cur_state <= S_IF;
                end
                S_TRAP: begin
                    if (trap_clr) begin
                        trap      <= 1'b0;
                        wait_cnt  <= '0;
                        cur_state <= S_IF;
                    end
                end
                default: begin
                    wait_cnt  <= '0;
                    cur_state <= S_IF;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: instruction sequencing, memory waits,
// illegal-opcode and timeout traps, counter wrap and mid-handshake reset.
module tb_multicycle_ctrl;
    import ctrl_pkg::*;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [6:0]    opcode = '0;
    logic [2:0]    funct3 = '0;
    logic [6:0]    funct7 = '0;
    logic          imem_ack = 1'b0;
    logic          dmem_ack = 1'b0;
    logic          trap_clr = 1'b0;
    logic          imem_req, dmem_req, ram_we, ir_we, pc_we, rf_we;
    logic [2:0]    alu_op, sext_op, state;
    logic          alub_sel, trap, trap_cause;
    logic [1:0]    npc_op, rf_wsel;
    logic [CW-1:0] retired;

    int checks = 0;
    int errors = 0;

    multicycle_ctrl #(.TIMEOUT(4), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .funct3     (funct3),
        .funct7     (funct7),
        .imem_ack   (imem_ack),
        .dmem_ack   (dmem_ack),
        .trap_clr   (trap_clr),
        .imem_req   (imem_req),
        .dmem_req   (dmem_req),
        .ram_we     (ram_we),
        .ir_we      (ir_we),
        .pc_we      (pc_we),
        .rf_we      (rf_we),
        .alu_op     (alu_op),
        .alub_sel   (alub_sel),
        .sext_op    (sext_op),
        .npc_op     (npc_op),
        .rf_wsel    (rf_wsel),
        .state      (state),
        .trap       (trap),
        .trap_cause (trap_cause),
        .retired    (retired)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    // In IF with ack: checks the fetch pulse, then presents the instruction in ID.
    task automatic fetch(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        imem_ack = 1'b1;
        #1;
        check("if_ir_we", ir_we, 1'b1);
        step();
        imem_ack = 1'b0;
        opcode   = op;
        funct3   = f3;
        funct7   = f7;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(negedge clk);
        check("rst_state",   state, S_IF);
        check("rst_imem",    imem_req, 1'b1);
        check("rst_dmem",    dmem_req, 1'b0);
        check("rst_alu",     alu_op, ALU_OP_AND);
        check("rst_sext",    sext_op, SEXT_OP_DEFAULT);
        check("rst_npc",     npc_op, NPC_OP_PC4);
        check("rst_wsel",    rf_wsel, RF_WSEL_ALU);
        check("rst_trap",    trap, 1'b0);
        check("rst_retired", retired, 0);
        rst = 1'b0;
        #1;

        // R-type add: IF, ID, EX, WB
        check("add_if_pc_we", pc_we, 1'b0);
        fetch(OP_R, 3'b000, 7'b0000000);
        check("add_id_state", state, S_ID);
        check("add_id_rf_we", rf_we, 1'b0);
        step();
        check("add_ex_state", state, S_EX);
        check("add_ex_alu",   alu_op, ALU_OP_ADD);
        check("add_ex_pc_we", pc_we, 1'b0);
        step();
        check("add_wb_state", state, S_WB);
        check("add_wb_rf_we", rf_we, 1'b1);
        check("add_wb_pc_we", pc_we, 1'b1);
        check("add_wb_ret",   retired, 0);
        step();
        check("add_done_state", state, S_IF);
        check("add_done_rf_we", rf_we, 1'b0);
        check("add_done_ret",   retired, 1);

        // Load with three wait cycles in MEM
        fetch(OP_LOAD, 3'b010, 7'b0);
        step();
        check("ld_ex_state", state, S_EX);
        step();
        for (int i = 0; i < 3; i++) begin
            check("ld_mem_state", state, S_MEM);
            check("ld_mem_req",   dmem_req, 1'b1);
            check("ld_mem_we",    ram_we, READ);
            check("ld_mem_pc_we", pc_we, 1'b0);
            step();
        end
        dmem_ack = 1'b1;
        #1;
        check("ld_ack_state", state, S_MEM);
        check("ld_ack_we",    ram_we, READ);
        check("ld_ack_pc_we", pc_we, 1'b0);
        step();
        dmem_ack = 1'b0;
        #1;
        check("ld_wb_state", state, S_WB);
        check("ld_wb_rf_we", rf_we, 1'b1);
        check("ld_wb_wsel",  rf_wsel, RF_WSEL_DRAM);
        step();
        check("ld_done_ret", retired, 2);

        // Store with immediate ack
        fetch(OP_S, 3'b010, 7'b0);
        check("st_id_rf_we", rf_we, 1'b0);
        step();
        check("st_ex_rf_we", rf_we, 1'b0);
        step();
        dmem_ack = 1'b1;
        #1;
        check("st_mem_state", state, S_MEM);
        check("st_mem_req",   dmem_req, 1'b1);
        check("st_mem_we",    ram_we, WRITE);
        check("st_mem_pc_we", pc_we, 1'b1);
        check("st_mem_rf_we", rf_we, 1'b0);
        step();
        dmem_ack = 1'b0;
        #1;
        check("st_done_state", state, S_IF);
        check("st_done_we",    ram_we, READ);
        check("st_done_ret",   retired, 3);

        // Branch: retires from EX
        fetch(OP_B, 3'b000, 7'b0);
        step();
        check("br_ex_state", state, S_EX);
        check("br_ex_pc_we", pc_we, 1'b1);
        check("br_ex_npc",   npc_op, NPC_OP_BR);
        check("br_ex_alu",   alu_op, ALU_OP_SUB);
        step();
        check("br_done_state", state, S_IF);
        check("br_done_ret",   retired, 4);

        // JAL fields
        fetch(OP_JAL, 3'b000, 7'b0);
        step();
        check("jal_npc",  npc_op, NPC_OP_JMP);
        check("jal_sext", sext_op, SEXT_OP_J);
        check("jal_wsel", rf_wsel, RF_WSEL_PC4);
        step();
        check("jal_wb_state", state, S_WB);
        step();

        // SRAI fields
        fetch(OP_I, 3'b101, 7'b0100000);
        step();
        check("srai_alu",  alu_op, ALU_OP_SRA);
        check("srai_sext", sext_op, SEXT_OP_SHAMT);
        check("srai_alub", alub_sel, ALUB_SEL_IMM);
        step();
        step();
        check("srai_done_ret", retired, 6);

        // Illegal opcode
        fetch(7'b1111111, 3'b000, 7'b0);
        step();
        check("ill_state", state, S_TRAP);
        check("ill_trap",  trap, 1'b1);
        check("ill_cause", trap_cause, CAUSE_ILLEGAL);
        check("ill_pc_we", pc_we, 1'b0);
        check("ill_imem",  imem_req, 1'b0);
        check("ill_npc_kept", npc_op, NPC_OP_PC4);
        step();
        check("ill_hold_state", state, S_TRAP);
        check("ill_hold_ret",   retired, 6);
        trap_clr = 1'b1;
        step();
        trap_clr = 1'b0;
        #1;
        check("ill_clr_state", state, S_IF);
        check("ill_clr_trap",  trap, 1'b0);

        // Fetch timeout: four IF cycles without ack
        for (int i = 0; i < 3; i++) begin
            step();
            check("to_wait_state", state, S_IF);
            check("to_wait_trap",  trap, 1'b0);
        end
        step();
        check("to_state", state, S_TRAP);
        check("to_trap",  trap, 1'b1);
        check("to_cause", trap_cause, CAUSE_TIMEOUT);
        check("to_imem",  imem_req, 1'b0);
        trap_clr = 1'b1;
        step();
        trap_clr = 1'b0;
        #1;
        check("to_clr_state", state, S_IF);

        // Ack on the fourth cycle beats the timeout
        step();
        step();
        step();
        imem_ack = 1'b1;
        #1;
        check("ack4_ir_we", ir_we, 1'b1);
        step();
        imem_ack = 1'b0;
        opcode   = OP_LUI;
        #1;
        check("ack4_state", state, S_ID);
        check("ack4_trap",  trap, 1'b0);
        step();
        check("lui_wsel", rf_wsel, RF_WSEL_SEXT);
        step();
        step();
        check("lui_done_ret", retired, 7);

        // Counter wraps modulo 16: ten more branches take 7 -> 17 -> 1
        for (int i = 0; i < 10; i++) begin
            fetch(OP_B, 3'b001, 7'b0);
            step();
            step();
        end
        check("wrap_ret", retired, 1);

        // Reset asserted mid-MEM drops dmem_req at once
        fetch(OP_LOAD, 3'b010, 7'b0);
        step();
        step();
        check("rstm_req_before", dmem_req, 1'b1);
        rst = 1'b1;
        #1;
        check("rstm_req_now", dmem_req, 1'b0);
        check("rstm_state",   state, S_IF);
        step();
        rst = 1'b0;
        step();
        check("rstm_after_state", state, S_IF);
        check("rstm_after_ret",   retired, 0);
        check("rstm_after_trap",  trap, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
